// File: rtl/uart_rx_capture_if.sv
// Received-byte stream from uart_rx_capture: a first-word-fall-through valid/ready
// byte channel plus the receiver's status pulses.
interface uart_rx_capture_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_error;
    logic       overrun;
    logic       busy;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_error,
        output overrun,
        output busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_error,
        input  overrun,
        input  busy,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver: synchronizes the line, samples each bit at mid-period,
// buffers bytes in a small FWFT FIFO and pulses framing/overrun errors.
module uart_rx_capture #(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              system_clock,
    input  logic              system_reset,
    input  logic              uart_rtl_rxd,
    uart_rx_capture_if.master rx_bus
);

    localparam int CNT_W  = $clog2(CLK_DIV);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLK_DIV / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    rx_state_t        state;
    rx_state_t        state_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_next;
    logic [7:0]       shreg;
    logic [7:0]       shreg_next;

    logic             sync_meta;
    logic             rxs;
    logic             rxs_d;

    logic             stop_good;
    logic             stop_bad;
    logic             frame_error_q;
    logic             overrun_q;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             drop;

    // Line idles high, so the synchronizer and edge detector reset to 1 to
    // avoid a false start edge when reset is released.
    always_ff @(posedge system_clock or posedge system_reset) begin
        if (system_reset) begin
            sync_meta <= 1'b1;
            rxs       <= 1'b1;
            rxs_d     <= 1'b1;
        end else begin
            sync_meta <= uart_rtl_rxd;
            rxs       <= sync_meta;
            rxs_d     <= rxs;
        end
    end

    always_ff @(posedge system_clock or posedge system_reset) begin
        if (system_reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            bit_idx <= bit_idx_next;
            shreg   <= shreg_next;
        end
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        stop_good    = 1'b0;
        stop_bad     = 1'b0;

        unique case (state)
            IDLE: begin
                if (rxs_d && !rxs) begin
                    bit_cnt_next = HALF_RELOAD;
                    state_next   = START;
                end
            end

            // A start bit that is high again at its midpoint was only a glitch.
            START: begin
                if (bit_cnt == '0) begin
                    if (rxs) begin
                        state_next = IDLE;
                    end else begin
                        bit_cnt_next = BIT_RELOAD;
                        bit_idx_next = '0;
                        state_next   = DATA;
                    end
                end else begin
                    bit_cnt_next = bit_cnt - 1'b1;
                end
            end

            DATA: begin
                if (bit_cnt == '0) begin
                    shreg_next   = {rxs, shreg[7:1]};
                    bit_cnt_next = BIT_RELOAD;
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    bit_cnt_next = bit_cnt - 1'b1;
                end
            end

            STOP: begin
                if (bit_cnt == '0) begin
                    if (rxs) begin
                        stop_good  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end else begin
                    bit_cnt_next = bit_cnt - 1'b1;
                end
            end

            // Holding here until the line is high gives one frame_error per break.
            WAIT_IDLE: begin
                if (rxs) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Overrun is judged after any same-cycle pop, so a full FIFO being read
    // still accepts the incoming byte.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign pop        = !fifo_empty && rx_bus.rx_ready;
    assign push       = stop_good && (!fifo_full || pop);
    assign drop       = stop_good && fifo_full && !pop;

    always_ff @(posedge system_clock or posedge system_reset) begin
        if (system_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge system_clock) begin
        if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= shreg;
        end
    end

    always_ff @(posedge system_clock or posedge system_reset) begin
        if (system_reset) begin
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            frame_error_q <= stop_bad;
            overrun_q     <= drop;
        end
    end

    // Storage is not reset, so the head is masked while empty.
    assign rx_bus.rx_data     = fifo_empty ? 8'h00 : mem[rd_ptr[ADDR_W-1:0]];
    assign rx_bus.rx_valid    = !fifo_empty;
    assign rx_bus.frame_error = frame_error_q;
    assign rx_bus.overrun     = overrun_q;
    assign rx_bus.busy        = (state != IDLE);

endmodule

// File: doc/uart_rx_capture.md
# uart_rx_capture

Synthesizable 8N1 UART receiver that decodes the serial stream leaving the MicroBlaze SoC on `uart_rtl_txd` and presents received bytes on a first-word-fall-through valid/ready byte interface. It sits at the far end of the SoC's UART link, in the FPGA-level test harness or a loopback monitor. It synchronizes the line, detects and qualifies start bits, samples each bit at mid-period, buffers bytes in a small FIFO, and flags framing and overrun errors.

## Interface

**Parameters**
- `CLK_DIV`, default 868: system clocks per bit (100 MHz / 115200). Must be ≥ 4.
- `FIFO_DEPTH`, default 4: byte buffer entries. Power of two, ≥ 2.

**Ports**
- `system_clock`, in, 1: single clock; every register is clocked on its rising edge.
- `system_reset`, in, 1: asynchronous, active-high reset.
- `uart_rtl_rxd`, in, 1: serial input; idle high. Connects to the SoC's `uart_rtl_txd`.
- `rx_data`, out, 8: byte at the FIFO head. Valid only while `rx_valid` = 1.
- `rx_valid`, out, 1: FIFO not empty.
- `rx_ready`, in, 1: consumer accepts. A pop occurs on a cycle with `rx_valid && rx_ready`.
- `frame_error`, out, 1: one-cycle pulse when a stop bit is sampled low.
- `overrun`, out, 1: one-cycle pulse when a good byte arrives while the FIFO is full.
- `busy`, out, 1: receiver state ≠ IDLE.

## Operation

**Line input**
- `uart_rtl_rxd` passes through a 2-FF synchronizer; its reset value is 1.
- `rxs` is the synchronized line level.
- `rxs_d` is `rxs` delayed by one clock; its reset value is 1.

**FSM states:** IDLE, START, DATA, STOP, WAIT_IDLE.
- **IDLE:** when `rxs_d` = 1 and `rxs` = 0 (falling edge), load `bit_cnt` with CLK_DIV/2 − 1 and go to START.
- **START:** when `bit_cnt` = 0, sample `rxs`.
  - If `rxs` = 1, treat it as a glitch and return to IDLE. No flag is raised.
  - If `rxs` = 0, load CLK_DIV − 1, clear `bit_idx`, and go to DATA.
- **DATA:** when `bit_cnt` = 0, shift `rxs` into `shreg` LSB-first (`shreg` ← {`rxs`, `shreg`[7:1]}), reload CLK_DIV − 1, and increment `bit_idx`. After the 8th sample (`bit_idx` = 7), go to STOP.
- **STOP:** when `bit_cnt` = 0, sample `rxs`.
  - If `rxs` = 1: push `shreg` into the FIFO, or pulse `overrun` if the FIFO is full and drop the byte. Go to IDLE.
  - If `rxs` = 0: pulse `frame_error`, discard the byte, and go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `rxs` = 1, then go to IDLE. This covers breaks and line held low, so a low line produces exactly one `frame_error` per frame.

**Counter and index**
- `bit_cnt` is ceil(log2(CLK_DIV)) bits wide and decrements every cycle outside IDLE and WAIT_IDLE.
- `bit_idx` is 3 bits. Wrap-around is not used; the state exit happens at 7.

**FIFO**
- Circular buffer with read and write pointers of log2(FIFO_DEPTH) + 1 bits.
- Empty when the pointers are fully equal. Full when the MSBs differ and the remaining bits are equal.
- `rx_data` = mem[rd_ptr]. This is combinational read, first-word fall-through.
- Simultaneous push and pop on a full FIFO: the pop frees a slot, so the push succeeds with no overrun. Overrun is evaluated against the post-pop occupancy.
- Pop when empty is ignored.

**Reset**
- Asserting `system_reset` at any time, including mid-frame, immediately forces IDLE, empties the FIFO, and clears counters and `shreg`.
- A frame interrupted by reset is lost. Reception resumes at the next falling edge after release.

## Timing

**Reset values**
- `rx_data` = 8'h00 (mem is not reset, but the output is masked to 0 while empty).
- `rx_valid` = 0, `frame_error` = 0, `overrun` = 0, `busy` = 0.

**Latency**
- The START mid-sample occurs CLK_DIV/2 cycles after edge detection.
- Data bit k is sampled (k + 1)·CLK_DIV cycles after the start mid-sample.
- `rx_valid` rises on the clock edge following the stop-bit mid-sample. That is 2 (sync) + 1 (edge) + CLK_DIV/2 + 9·CLK_DIV cycles after the line falls, within ±1 cycle.

**Pops and flags**
- A pop takes effect at the edge where `rx_valid && rx_ready`. `rx_data` and `rx_valid` update on that same edge.
- Back-to-back pops are allowed every cycle.
- `frame_error` and `overrun` are registered and high for exactly one cycle, on the cycle after the stop sample.

**Back-to-back frames**
- A new start edge is accepted from the first cycle in IDLE. Bytes separated by a full stop bit are all received.

## Test plan

All scenarios use CLK_DIV = 16 and FIFO_DEPTH = 4, with bits driven at 16 clocks each.

1. **Single byte:** send 8'h55 with `rx_ready` = 0. Required: `rx_valid` = 1 with `rx_data` = 8'h55 about 150 cycles after the start edge, and no flags. Raise `rx_ready`, then `rx_valid` = 0 on the next cycle.
2. **Back-to-back:** send 8'hA5, 8'h00, 8'hFF, 8'h3C continuously with `rx_ready` = 0. Required: FIFO full, and popping yields A5, 00, FF, 3C in order. A fifth byte 8'h81 sent before any pop produces an `overrun` pulse, and 8'h81 is never output.
3. **Framing error:** send 8'hC3 with the stop bit low, then hold the line low for 40 cycles. Required: exactly one `frame_error` pulse, no byte pushed, and `busy` stays 1 until the line returns high. A subsequent 8'h12 is received correctly.
4. **Glitch rejection:** drive the line low for 5 cycles, then high. Required: `busy` pulses through START and returns to IDLE; no `rx_valid`, no flags.
5. **Full with simultaneous pop:** fill 4 bytes, then hold `rx_ready` = 1 on exactly the cycle the fifth byte 8'h77 is pushed. Required: no `overrun`, and the FIFO holds 4 bytes ending in 8'h77.
6. **Reset mid-frame:** assert `system_reset` during bit 4 of 8'h9E. Required: all outputs at reset values immediately. A subsequent 8'h42 is received as 8'h42.
